// File: rtl/elastic_pipe_reg_pkg.sv
// Shared definitions for the elastic pipeline register chain.
// Stage state encoding; 2'b11 is unused and is steered back to ST_EMPTY.
package elastic_pipe_reg_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_BUSY  = 2'b01,
    ST_FULL  = 2'b10
  } stage_state_e;

  localparam int unsigned STATE_W = 2;

endpackage : elastic_pipe_reg_pkg

// File: rtl/elastic_pipe_reg_skid_stage.sv
// One elastic stage: a main register plus a skid register. Ready upstream depends
// only on local state, so out_ready never reaches in_ready combinationally.
module elastic_skid_stage
  import elastic_pipe_reg_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  stage_state_e     r_state;
  stage_state_e     w_state_nxt;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic             w_up_fire;
  logic             w_dn_fire;
  logic             w_load_main;
  logic             w_main_from_skid;
  logic             w_load_skid;

  assign in_ready  = (r_state != ST_FULL);
  assign out_valid = (r_state != ST_EMPTY);
  assign out_data  = r_main;

  assign w_up_fire = in_valid && in_ready;
  assign w_dn_fire = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and register-load enables; flush overrides everything.
  always_comb begin
    w_state_nxt      = r_state;
    w_load_main      = 1'b0;
    w_main_from_skid = 1'b0;
    w_load_skid      = 1'b0;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_up_fire) begin
            w_state_nxt = ST_BUSY;
            w_load_main = 1'b1;
          end
        end
        ST_BUSY: begin
          if (w_up_fire && w_dn_fire) begin
            w_load_main = 1'b1;
          end else if (w_up_fire) begin
            w_state_nxt = ST_FULL;
            w_load_skid = 1'b1;
          end else if (w_dn_fire) begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (w_dn_fire) begin
            w_state_nxt      = ST_BUSY;
            w_main_from_skid = 1'b1;
          end
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  // Payload registers keep their contents across flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      if (w_load_main) begin
        r_main <= in_data;
      end else if (w_main_from_skid) begin
        r_main <= r_skid;
      end
      if (w_load_skid) begin
        r_skid <= in_data;
      end
    end
  end

endmodule : elastic_skid_stage

// File: rtl/elastic_pipe_reg.sv
// Chain of STAGES elastic skid stages with valid/ready on both ends, synchronous
// flush and a whole-chain occupancy count.
module elastic_pipe_reg
  import elastic_pipe_reg_pkg::*;
#(
  parameter  int unsigned WIDTH  = 32,
  parameter  int unsigned STAGES = 1,
  localparam int unsigned CW     = $clog2(2 * STAGES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    occupancy
);

  logic [STAGES:0]  w_valid;
  logic [STAGES:0]  w_ready;
  logic [WIDTH-1:0] w_data [STAGES+1];
  logic             w_in_fire;
  logic             w_out_fire;
  logic [CW-1:0]    r_occ;

  assign w_valid[0]      = in_valid;
  assign w_data[0]       = in_data;
  assign in_ready        = w_ready[0];
  assign out_valid       = w_valid[STAGES];
  assign out_data        = w_data[STAGES];
  assign w_ready[STAGES] = out_ready;

  // Stage k consumes link k and produces link k+1.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    elastic_skid_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .in_valid (w_valid[k]),
      .in_ready (w_ready[k]),
      .in_data  (w_data[k]),
      .out_valid(w_valid[k+1]),
      .out_ready(w_ready[k+1]),
      .out_data (w_data[k+1])
    );
  end

  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_occ <= '0;
    end else if (flush) begin
      r_occ <= '0;
    end else begin
      r_occ <= r_occ + CW'(w_in_fire) - CW'(w_out_fire);
    end
  end

  assign occupancy = r_occ;

endmodule : elastic_pipe_reg

// File: doc/elastic_pipe_reg.md
# elastic_pipe_reg

Parametrised, flow-controlled successor to the fixed IF/ID/EXE stage registers: a chain of STAGES elastic register stages carrying a WIDTH-bit payload with a valid/ready handshake on both ends, per-stage skid buffering, synchronous flush and an occupancy count. It sits between any two pipeline stages of the ARM core so a stage can stall or drop its contents without the hard-wired freeze/flush inputs the current stage registers tie to zero. Full throughput is sustained when the consumer is always ready.

## Interface
- WIDTH, 32, payload width in bits (≥1)
- STAGES, 1, number of elastic stages in the chain (≥1)
- CW, $clog2(2*STAGES+1), occupancy counter width (derived, not overridden)

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous discard of all held entries
- in_valid  in  1  producer presents in_data
- in_ready  out  1  chain accepts a word this cycle
- in_data  in  WIDTH  payload from producer
- out_valid  out  1  out_data holds a valid word
- out_ready  in  1  consumer accepts out_data this cycle
- out_data  out  WIDTH  payload to consumer
- occupancy  out  CW  number of words held in the whole chain

## Operation
- Handshake: a transfer occurs on a rising edge where valid && ready; in_fire = in_valid && in_ready, out_fire = out_valid && out_ready.
- Each stage holds a main register and a skid register; state per stage: EMPTY (neither held), BUSY (main held), FULL (main + skid held).
- Stage ready upstream = (state != FULL), a pure function of stage state (no combinational path from out_ready to in_ready).
- Stage valid downstream = (state != EMPTY); stage data = main register.
- EMPTY: up-fire -> BUSY, main <= incoming.
- BUSY: up-fire only -> FULL, skid <= incoming; down-fire only -> EMPTY; both -> BUSY, main <= incoming.
- FULL: down-fire -> BUSY, main <= skid; upstream not ready, so no up-fire possible.
- Stage k output feeds stage k+1 input; stage 0 input is the in_* port, stage STAGES-1 output is the out_* port.
- Occupancy: next = occupancy + in_fire - out_fire; range 0..2*STAGES.
- Flush: all stages -> EMPTY next edge, occupancy -> 0; a concurrent in_fire is dropped, a concurrent out_fire still counts as consumed by the consumer. Data registers are not cleared by flush.
- Flush has priority over every other transition.
- Data is never reordered, duplicated or dropped except by flush.

## Timing
- Reset (async, immediate): all stages EMPTY, all data registers 0; out_valid=0, out_data=0, in_ready=1, occupancy=0.
- Latency: word accepted at edge N is at out_data with out_valid=1 after edge N+STAGES-1, i.e. visible in cycle N+STAGES when no stall.
- Throughput: 1 word/cycle with out_ready held 1.
- Back-pressure: with out_ready=0, chain absorbs exactly 2*STAGES words, then in_ready=0 in the cycle after the last accept.
- Release: in_ready returns to 1 in the cycle after the out_fire that empties stage 0's skid.
- Flush: in_ready=1, out_valid=0, occupancy=0 in the cycle after the flush edge.
- Reset mid-operation: all held words lost, outputs return to reset values asynchronously.

## Structure
- Shared defs header (pipe_defs): stage state encoding EMPTY=2'b00, BUSY=2'b01, FULL=2'b10; 2'b11 illegal, recovers to EMPTY.
- Sub-module elastic_skid_stage (WIDTH parameter): one stage's state machine, main and skid registers, flush input.
- Top generates STAGES instances and the occupancy counter.

## Test plan
- Reset then stream 0x00000001..0x00000008 with out_ready=1, STAGES=2 -> outputs 1..8 in order, first out_valid two cycles after first accept, no gaps, occupancy never >2.
- STAGES=2, out_ready=0, in_valid=1 with 0xA0..0xA5 -> 0xA0..0xA3 accepted, in_ready=0 thereafter, occupancy=4; raise out_ready -> 0xA0..0xA5 delivered in order.
- Random out_ready (50%), 1000 words, STAGES=3 -> scoreboard exact order match, occupancy equals in-flight count every cycle.
- Load 3 words into STAGES=2, assert flush with in_valid=1 data 0xDEAD -> next cycle occupancy=0, out_valid=0, in_ready=1; 0xDEAD never appears at output.
- Assert rst asynchronously between edges with occupancy=3 -> out_valid=0, out_data=0, occupancy=0 immediately, in_ready=1.
- STAGES=1, WIDTH=8, alternating in_valid/out_ready toggles -> FULL entered and left correctly, data 0x5A/0xA5 pattern preserved.
